// File: rtl/fpu_result_serializer.sv
// fpu_result_serializer
//
// Output stage behind the FPU control block. Results from the adder and
// multiplier control units are captured into a small FIFO. Each captured
// 32-bit result is returned to the host as two 16-bit halves, upper half first.
//
// Handshakes:
//   Producer side: xxx_VALID is a level that the producer holds until it sees
//     the one-cycle xxx_ACK pulse. The pulse arrives the cycle after the
//     accepting edge. A per-source arm flag blocks a second capture of a VALID
//     that is still high during the ACK cycle. The flag is re-armed once VALID
//     is sampled low.
//   Host side: a half-word transfers at an edge where DOV and DOA are both
//     high. DOUT, EXC and DOV stay stable while DOA is low. DOA is ignored
//     while DOV is low.
//
// Ports:
//   CLK, RSTn            clock (rising edge), synchronous active-low reset
//   ADD_DATA/EXC/VALID   adder result, exception code and valid level
//   ADD_ACK              adder result accepted (one-cycle pulse)
//   MUL_DATA/EXC/VALID   multiplier result, exception code and valid level
//   MUL_ACK              multiplier result accepted (one-cycle pulse)
//   DR                   a word is in transfer or the FIFO is non-empty
//   DOUT, DOV, DOA       host half-word bus, valid and accept
//   EXC                  exception code of the word currently on DOUT
//   FULL                 FIFO holds DEPTH entries
//   DEBUG (optional)     {state, min(count,7)}. Present only when the macro
//                        FPU_OUT_DEBUG_EN is defined.
module fpu_result_serializer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [DATA_W-1:0] ADD_DATA,
  input  logic [2:0]        ADD_EXC,
  input  logic              ADD_VALID,
  output logic              ADD_ACK,
  input  logic [DATA_W-1:0] MUL_DATA,
  input  logic [2:0]        MUL_EXC,
  input  logic              MUL_VALID,
  output logic              MUL_ACK,
  output logic              DR,
  output logic [OUT_W-1:0]  DOUT,
  output logic              DOV,
  input  logic              DOA,
  output logic [2:0]        EXC,
  output logic              FULL
`ifdef FPU_OUT_DEBUG_EN
  ,
  output logic [4:0]        DEBUG
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + 3 + DATA_W;  // {src, exc, data}

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } state_t;

  state_t            state_q;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              add_arm_q, mul_arm_q;
  logic              prio_q;      // 0: adder wins next conflict, 1: multiplier
  logic [OUT_W-1:0]  out_lo_q;    // lower half waiting behind the upper half

  logic              can_push, add_req, mul_req, add_win, mul_win, push, pop;
  logic [ENT_W-1:0]  push_entry, head;
  logic              unused_src;

  // Room is judged on the registered count only, so a pop at the same edge
  // never frees a slot for that edge's capture.
  assign can_push   = (count_q < CNT_W'(DEPTH));
  assign add_req    = ADD_VALID & add_arm_q;
  assign mul_req    = MUL_VALID & mul_arm_q;
  assign add_win    = can_push & add_req & (~mul_req | ~prio_q);
  assign mul_win    = can_push & mul_req & (~add_req |  prio_q);
  assign push       = add_win | mul_win;
  assign push_entry = add_win ? {1'b0, ADD_EXC, ADD_DATA} : {1'b1, MUL_EXC, MUL_DATA};
  assign head       = mem_q[rd_ptr_q];
  // The source tag is stored with each entry but nothing downstream needs it.
  assign unused_src = head[ENT_W-1];

  // Head is taken from IDLE, or at the end of a lower half. The second case
  // gives back-to-back words with no bubble.
  assign pop = (count_q != '0) &
               ((state_q == IDLE) | ((state_q == SEND_LO) & DOA));

  assign DR   = (state_q != IDLE) | (count_q != '0);
  assign FULL = (count_q == CNT_W'(DEPTH));

`ifdef FPU_OUT_DEBUG_EN
  logic [2:0] dbg_cnt;
  assign dbg_cnt = ({{(32-CNT_W){1'b0}}, count_q} > 32'd7) ? 3'd7 : 3'(count_q);
  assign DEBUG   = {state_q, dbg_cnt};
`endif

  // Capture: acknowledge, re-arm, and round-robin on conflicts only.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ADD_ACK   <= 1'b0;
      MUL_ACK   <= 1'b0;
      add_arm_q <= 1'b1;
      mul_arm_q <= 1'b1;
      prio_q    <= 1'b0;
    end else begin
      ADD_ACK   <= add_win;
      MUL_ACK   <= mul_win;
      add_arm_q <= add_win ? 1'b0 : (~ADD_VALID | add_arm_q);
      mul_arm_q <= mul_win ? 1'b0 : (~MUL_VALID | mul_arm_q);
      if (add_req & mul_req & can_push) prio_q <= ~prio_q;
    end
  end

  // FIFO storage. The entries need no reset because count gates every read.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output FSM. DOUT, EXC and DOV are registered here. DOUT keeps its last
  // value in IDLE, and DOV says whether that value is meaningful.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      DOUT     <= '0;
      DOV      <= 1'b0;
      EXC      <= 3'b000;
      out_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            DOUT     <= head[DATA_W-1:OUT_W];
            out_lo_q <= head[OUT_W-1:0];
            EXC      <= head[DATA_W+2:DATA_W];
            DOV      <= 1'b1;
            state_q  <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (DOA) begin
            DOUT    <= out_lo_q;
            state_q <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (DOA) begin
            if (pop) begin
              DOUT     <= head[DATA_W-1:OUT_W];
              out_lo_q <= head[OUT_W-1:0];
              EXC      <= head[DATA_W+2:DATA_W];
              state_q  <= SEND_HI;
            end else begin
              DOV     <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          DOV     <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_result_serializer.sv
// Directed testbench for fpu_result_serializer.
// Inputs change 1 ns after a rising edge, and outputs are checked in the same
// window. "Cycle n" is the window that follows the n-th edge of a scenario.
module tb_fpu_result_serializer;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] ADD_DATA, MUL_DATA;
  logic [2:0]  ADD_EXC, MUL_EXC, EXC;
  logic        ADD_VALID, MUL_VALID, ADD_ACK, MUL_ACK;
  logic        DR, DOV, DOA, FULL;
  logic [15:0] DOUT;

  int tests_run    = 0;
  int tests_failed = 0;

  fpu_result_serializer #(.DEPTH(4), .DATA_W(32), .OUT_W(16)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .ADD_DATA(ADD_DATA), .ADD_EXC(ADD_EXC), .ADD_VALID(ADD_VALID), .ADD_ACK(ADD_ACK),
    .MUL_DATA(MUL_DATA), .MUL_EXC(MUL_EXC), .MUL_VALID(MUL_VALID), .MUL_ACK(MUL_ACK),
    .DR(DR), .DOUT(DOUT), .DOV(DOV), .DOA(DOA), .EXC(EXC), .FULL(FULL)
  );

  // Clock and global time limit
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Hold ADD_VALID until the ACK pulse, then drop it for one edge so the
  // source re-arms.
  task automatic push_add(input logic [31:0] d, input logic [2:0] e);
    logic got;
    got = 1'b0;
    ADD_DATA = d; ADD_EXC = e; ADD_VALID = 1'b1;
    for (int k = 0; k < 16 && !got; k++) begin
      step();
      if (ADD_ACK === 1'b1) got = 1'b1;
    end
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL push_ack: got=%b want 1 for %h", got, d); end
    ADD_VALID = 1'b0;
    step();
  endtask

  // Scenarios
  task automatic test_reset();
    RSTn = 1'b0; DOA = 1'b0;
    ADD_VALID = 1'b0; MUL_VALID = 1'b0;
    ADD_DATA = '0; MUL_DATA = '0; ADD_EXC = '0; MUL_EXC = '0;
    step(); step();
    tests_run++; if ({ADD_ACK, MUL_ACK, DR, DOV, FULL} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags: ack/dr/dov/full=%b want 00000", {ADD_ACK, MUL_ACK, DR, DOV, FULL}); end
    tests_run++; if (DOUT !== 16'h0000) begin tests_failed++; $display("FAIL reset_dout: DOUT=%h want 0000", DOUT); end
    tests_run++; if (EXC !== 3'b000) begin tests_failed++; $display("FAIL reset_exc: EXC=%b want 000", EXC); end
    RSTn = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    DOA = 1'b1;
    ADD_DATA = 32'h3F80_0000; ADD_EXC = 3'b000; ADD_VALID = 1'b1;  // cycle 0
    step();                                                        // cycle 1
    tests_run++; if (ADD_ACK !== 1'b1) begin tests_failed++; $display("FAIL single_ack: ADD_ACK=%b want 1", ADD_ACK); end
    tests_run++; if (DOV !== 1'b0) begin tests_failed++; $display("FAIL single_dov1: DOV=%b want 0", DOV); end
    tests_run++; if (DR !== 1'b1) begin tests_failed++; $display("FAIL single_dr1: DR=%b want 1", DR); end
    ADD_VALID = 1'b0;
    step();                                                        // cycle 2
    tests_run++; if (DOV !== 1'b1 || DOUT !== 16'h3F80) begin tests_failed++; $display("FAIL single_hi: DOV=%b DOUT=%h want 1 3f80", DOV, DOUT); end
    tests_run++; if (ADD_ACK !== 1'b0) begin tests_failed++; $display("FAIL single_ack_pulse: ADD_ACK=%b want 0", ADD_ACK); end
    step();                                                        // cycle 3
    tests_run++; if (DOV !== 1'b1 || DOUT !== 16'h0000) begin tests_failed++; $display("FAIL single_lo: DOV=%b DOUT=%h want 1 0000", DOV, DOUT); end
    step();                                                        // cycle 4
    tests_run++; if (DOV !== 1'b0 || DR !== 1'b0) begin tests_failed++; $display("FAIL single_idle: DOV=%b DR=%b want 0 0", DOV, DR); end
  endtask

  task automatic test_conflict();
    logic [15:0] exp1 [4];
    logic [15:0] exp2 [4];
    exp1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp2 = '{16'hCCCC, 16'hDDDD, 16'hAAAA, 16'hBBBB};
    DOA = 1'b1;
    ADD_DATA = 32'h1111_2222; ADD_EXC = 3'b000; ADD_VALID = 1'b1;
    MUL_DATA = 32'h3333_4444; MUL_EXC = 3'b000; MUL_VALID = 1'b1;
    step();
    tests_run++; if ({ADD_ACK, MUL_ACK} !== 2'b10) begin tests_failed++; $display("FAIL conflict1_ack: add/mul=%b want 10", {ADD_ACK, MUL_ACK}); end
    ADD_VALID = 1'b0;
    step();
    tests_run++; if ({ADD_ACK, MUL_ACK} !== 2'b01) begin tests_failed++; $display("FAIL conflict1_mul_ack: add/mul=%b want 01", {ADD_ACK, MUL_ACK}); end
    MUL_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      tests_run++; if (DOV !== 1'b1 || DOUT !== exp1[i]) begin tests_failed++; $display("FAIL conflict1_out%0d: DOV=%b DOUT=%h want 1 %h", i, DOV, DOUT, exp1[i]); end
    end
    step();
    tests_run++; if (DOV !== 1'b0) begin tests_failed++; $display("FAIL conflict1_idle: DOV=%b want 0", DOV); end
    // Second conflict: the multiplier now holds priority.
    ADD_DATA = 32'hAAAA_BBBB; ADD_VALID = 1'b1;
    MUL_DATA = 32'hCCCC_DDDD; MUL_VALID = 1'b1;
    step();
    tests_run++; if ({ADD_ACK, MUL_ACK} !== 2'b01) begin tests_failed++; $display("FAIL conflict2_ack: add/mul=%b want 01", {ADD_ACK, MUL_ACK}); end
    MUL_VALID = 1'b0;
    step();
    tests_run++; if ({ADD_ACK, MUL_ACK} !== 2'b10) begin tests_failed++; $display("FAIL conflict2_add_ack: add/mul=%b want 10", {ADD_ACK, MUL_ACK}); end
    ADD_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      tests_run++; if (DOV !== 1'b1 || DOUT !== exp2[i]) begin tests_failed++; $display("FAIL conflict2_out%0d: DOV=%b DOUT=%h want 1 %h", i, DOV, DOUT, exp2[i]); end
    end
    step();
    tests_run++; if (DOV !== 1'b0) begin tests_failed++; $display("FAIL conflict2_idle: DOV=%b want 0", DOV); end
  endtask

  // w[0] leaves the FIFO at once for the output register. w[1]..w[4] then
  // fill all four FIFO entries, and w[5] must wait for a pop.
  task automatic test_back_pressure();
    logic [31:0] w [6];
    logic [15:0] exp_q [$];
    w = '{32'h0001_0002, 32'h0101_0102, 32'h0201_0202, 32'h0301_0302, 32'h0401_0402, 32'h0501_0502};
    DOA = 1'b0;
    for (int i = 0; i < 5; i++) push_add(w[i], 3'b000);
    tests_run++; if (FULL !== 1'b1) begin tests_failed++; $display("FAIL bp_full: FULL=%b want 1", FULL); end
    ADD_DATA = w[5]; ADD_VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++; if (ADD_ACK !== 1'b0 || FULL !== 1'b1) begin tests_failed++; $display("FAIL bp_block%0d: ACK=%b FULL=%b want 0 1", k, ADD_ACK, FULL); end
      tests_run++; if (DOV !== 1'b1 || DOUT !== 16'h0001) begin tests_failed++; $display("FAIL bp_stable%0d: DOV=%b DOUT=%h want 1 0001", k, DOV, DOUT); end
    end
    DOA = 1'b1;
    step();
    tests_run++; if (DOUT !== 16'h0002) begin tests_failed++; $display("FAIL bp_w0_lo: DOUT=%h want 0002", DOUT); end
    step();  // pop edge, with no room yet for w[5] at this same edge
    tests_run++; if (ADD_ACK !== 1'b0 || FULL !== 1'b0 || DOUT !== 16'h0101) begin tests_failed++; $display("FAIL bp_no_bypass: ACK=%b FULL=%b DOUT=%h want 0 0 0101", ADD_ACK, FULL, DOUT); end
    DOA = 1'b0;
    step();
    tests_run++; if (ADD_ACK !== 1'b1 || FULL !== 1'b1) begin tests_failed++; $display("FAIL bp_late_ack: ACK=%b FULL=%b want 1 1", ADD_ACK, FULL); end
    ADD_VALID = 1'b0;
    for (int i = 1; i < 6; i++) begin
      exp_q.push_back(w[i][15:0]);  // upper half of w[1] is already on DOUT
      if (i < 5) exp_q.push_back(w[i+1][31:16]);
    end
    DOA = 1'b1;
    while (exp_q.size() != 0) begin
      step();
      tests_run++; if (DOV !== 1'b1 || DOUT !== exp_q[0]) begin tests_failed++; $display("FAIL bp_drain: DOV=%b DOUT=%h want 1 %h", DOV, DOUT, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    step();
    tests_run++; if (DOV !== 1'b0 || DR !== 1'b0) begin tests_failed++; $display("FAIL bp_empty: DOV=%b DR=%b want 0 0", DOV, DR); end
  endtask

  task automatic test_held_valid();
    int acks;
    acks = 0;
    DOA = 1'b1;
    ADD_DATA = 32'h1234_5678; ADD_EXC = 3'b010; ADD_VALID = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (ADD_ACK === 1'b1) acks++;
      if (k == 2) begin
        tests_run++; if (DOUT !== 16'h1234 || EXC !== 3'b010) begin tests_failed++; $display("FAIL held_hi: DOUT=%h EXC=%b want 1234 010", DOUT, EXC); end
      end
      if (k == 3) begin
        tests_run++; if (DOUT !== 16'h5678) begin tests_failed++; $display("FAIL held_lo: DOUT=%h want 5678", DOUT); end
      end
      if (k == 4) ADD_VALID = 1'b0;
    end
    tests_run++; if (acks !== 1) begin tests_failed++; $display("FAIL held_acks: pulses=%0d want 1", acks); end
    tests_run++; if (DOV !== 1'b0 || DR !== 1'b0) begin tests_failed++; $display("FAIL held_single_entry: DOV=%b DR=%b want 0 0", DOV, DR); end
  endtask

  task automatic test_exception();
    DOA = 1'b1;
    MUL_DATA = 32'h7F80_0000; MUL_EXC = 3'b101; MUL_VALID = 1'b1;
    step();
    tests_run++; if (MUL_ACK !== 1'b1) begin tests_failed++; $display("FAIL exc_ack: MUL_ACK=%b want 1", MUL_ACK); end
    MUL_VALID = 1'b0;
    step();
    tests_run++; if (DOUT !== 16'h7F80 || EXC !== 3'b101) begin tests_failed++; $display("FAIL exc_hi: DOUT=%h EXC=%b want 7f80 101", DOUT, EXC); end
    step();
    tests_run++; if (DOUT !== 16'h0000 || EXC !== 3'b101 || DOV !== 1'b1) begin tests_failed++; $display("FAIL exc_lo: DOUT=%h EXC=%b DOV=%b want 0000 101 1", DOUT, EXC, DOV); end
    step();
  endtask

  task automatic test_reset_mid_transfer();
    DOA = 1'b0;
    push_add(32'hAB01_CD01, 3'b011);
    push_add(32'hAB02_CD02, 3'b011);
    push_add(32'hAB03_CD03, 3'b011);
    DOA = 1'b1;
    step();
    DOA = 1'b0;
    tests_run++; if (DOUT !== 16'hCD01 || DR !== 1'b1) begin tests_failed++; $display("FAIL mid_lo: DOUT=%h DR=%b want cd01 1", DOUT, DR); end
    RSTn = 1'b0;
    step();
    tests_run++; if ({DOV, DR, FULL} !== 3'b000) begin tests_failed++; $display("FAIL mid_reset: DOV/DR/FULL=%b want 000", {DOV, DR, FULL}); end
    tests_run++; if (DOUT !== 16'h0000 || EXC !== 3'b000) begin tests_failed++; $display("FAIL mid_reset_bus: DOUT=%h EXC=%b want 0000 000", DOUT, EXC); end
    RSTn = 1'b1; DOA = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++; if (DOV !== 1'b0 || DR !== 1'b0) begin tests_failed++; $display("FAIL mid_no_stale%0d: DOV=%b DR=%b want 0 0", k, DOV, DR); end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_conflict();
    test_back_pressure();
    test_held_valid();
    test_exception();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
